// File: rtl/key_sweep_ctrl_if.sv
// Sweep controller bus: sweep request, compare pattern, datapath key/data and sweep results.
`timescale 1ns/1ps
interface key_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [31:0] key_lo;
  logic [31:0] key_hi;
  logic [31:0] match_val;
  logic [31:0] match_mask;
  logic [31:0] key_out;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] found_key;
  logic [31:0] trial_count;
  logic [15:0] hit_count;

  modport master (
    output start, abort, key_lo, key_hi, match_val, match_mask, data_in,
    input  key_out, busy, done, found, found_key, trial_count, hit_count
  );

  modport slave (
    input  start, abort, key_lo, key_hi, match_val, match_mask, data_in,
    output key_out, busy, done, found, found_key, trial_count, hit_count
  );
endinterface

// File: rtl/key_sweep_ctrl.sv
// Steps key_out from key_lo to key_hi and compares the masked datapath response per key.
// Optional macro KEY_SWEEP_CONTINUE_EN: hits do not end the sweep, hit_count saturates.
`timescale 1ns/1ps
module key_sweep_ctrl #(
  parameter int unsigned LAT = 1
) (
  input logic             clk,
  input logic             rst,
  key_sweep_ctrl_if.slave bus
);
  localparam int unsigned KW = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, FIN} state_t;

  state_t        state;
  logic [KW-1:0] key_hi_q;
  logic [KW-1:0] val_q;
  logic [KW-1:0] mask_q;
  logic [CW-1:0] wait_cnt;
  logic          hit_c;
  logic          last_c;
  logic          stop_c;

  assign hit_c  = ((bus.data_in ^ val_q) & mask_q) == '0;
  assign last_c = bus.key_out == key_hi_q;
`ifdef KEY_SWEEP_CONTINUE_EN
  assign stop_c = last_c;
`else
  assign stop_c = last_c | hit_c;
`endif

  // The first key is presented on the start edge, so its WAIT is one cycle
  // shorter; later keys change on the CHECK edge and wait the full LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      key_hi_q        <= '0;
      val_q           <= '0;
      mask_q          <= '0;
      wait_cnt        <= '0;
      bus.key_out     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.found       <= 1'b0;
      bus.found_key   <= '0;
      bus.trial_count <= '0;
      bus.hit_count   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_hi_q        <= bus.key_hi;
            val_q           <= bus.match_val;
            mask_q          <= bus.match_mask;
            bus.found       <= 1'b0;
            bus.found_key   <= '0;
            bus.trial_count <= '0;
            bus.hit_count   <= '0;
            bus.busy        <= 1'b1;
            if (bus.key_lo > bus.key_hi) begin
              state <= FIN;
            end else begin
              bus.key_out <= bus.key_lo;
              wait_cnt    <= CW'(LAT - 1);
              state       <= (LAT == 1) ? CHECK : WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (wait_cnt <= CW'(1)) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        CHECK: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            bus.trial_count <= bus.trial_count + KW'(1);
            if (hit_c) begin
              if (bus.hit_count != '1) bus.hit_count <= bus.hit_count + HW'(1);
              if (!bus.found) bus.found_key <= bus.key_out;
              bus.found <= 1'b1;
            end
            if (stop_c) begin
              state <= FIN;
            end else begin
              bus.key_out <= bus.key_out + KW'(1);
              wait_cnt    <= CW'(LAT);
              state       <= WAIT;
            end
          end
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Bench for key_sweep_ctrl: LAT=1 and LAT=3 instances fed identical stimulus,
// checked against a key-by-key reference model of the sweep.
`timescale 1ns/1ps
module tb_key_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_sweep_ctrl_if if1 ();
  key_sweep_ctrl_if if3 ();

  key_sweep_ctrl #(.LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  key_sweep_ctrl #(.LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic [31:0] trials, hits, fkey, kout;
    logic        found, busy0, busy_end, done_now;
    int          done_edge, done_cnt;
  } exp_t;

  exp_t ex [2];
  exp_t ob [2];
  int   tests = 0;
  int   fails = 0;
  int   dp_mode = 0;
  logic [31:0] q1 = '0, q2 = '0;

  // Mode 0: only the reference key produces the reference word; mode 1: hash.
  function automatic logic [31:0] dp_f(input int mode, input logic [31:0] k);
    if (mode == 0) return (k == 32'h4C6F7452) ? 32'h12345678 : 32'h0;
    return {k[15:0], k[31:16]} ^ (k * 32'h9E3779B1);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  always_comb if1.data_in = dp_f(dp_mode, if1.key_out);
  always_ff @(posedge clk) begin
    q1 <= if3.key_out;
    q2 <= q1;
  end
  always_comb if3.data_in = dp_f(dp_mode, q2);

  // Key-by-key reference: trial i of a sweep is compared on edge lat+i*(lat+1) after the start edge.
  task automatic model(input int lat, input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] val, input logic [31:0] mask, input int ab, inout exp_t e);
    longint unsigned k;
    int i, ce;
    e.trials = 0; e.hits = 0; e.found = 1'b0; e.fkey = 0;
    e.busy0 = 1'b1; e.busy_end = 1'b0; e.done_now = 1'b0;
    e.done_edge = -1; e.done_cnt = 0;
    if (lo > hi) begin
      e.done_edge = 1; e.done_cnt = 1;
      return;
    end
    i = 0; ce = 0;
    for (k = longint'(lo); k <= longint'(hi); k++) begin
      ce = lat + i * (lat + 1);
      e.kout = 32'(k);
      if (ab > 0 && ab <= ce) return;
      e.trials = e.trials + 1;
      if ((dp_f(dp_mode, 32'(k)) & mask) == (val & mask)) begin
        if (e.hits < 32'd65535) e.hits = e.hits + 1;
        if (!e.found) begin e.found = 1'b1; e.fkey = 32'(k); end
`ifndef KEY_SWEEP_CONTINUE_EN
        e.done_edge = ce + 1; e.done_cnt = 1;
        return;
`endif
      end
      i++;
    end
    e.done_edge = ce + 1; e.done_cnt = 1;
  endtask

  task automatic snap();
    ob[0].kout = if1.key_out; ob[0].busy_end = if1.busy; ob[0].done_now = if1.done;
    ob[0].found = if1.found; ob[0].fkey = if1.found_key; ob[0].trials = if1.trial_count;
    ob[0].hits = {16'h0, if1.hit_count};
    ob[1].kout = if3.key_out; ob[1].busy_end = if3.busy; ob[1].done_now = if3.done;
    ob[1].found = if3.found; ob[1].fkey = if3.found_key; ob[1].trials = if3.trial_count;
    ob[1].hits = {16'h0, if3.hit_count};
  endtask

  task automatic drive(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] val,
                       input logic [31:0] mask, input logic st, input logic ab);
    if1.key_lo = lo; if1.key_hi = hi; if1.match_val = val; if1.match_mask = mask;
    if3.key_lo = lo; if3.key_hi = hi; if3.match_val = val; if3.match_mask = mask;
    if1.start = st; if3.start = st; if1.abort = ab; if3.abort = ab;
  endtask

  // Issues one start (abort on edge ab after the start edge, 0 = with start) and records done timing.
  task automatic run_sweep(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] val,
                           input logic [31:0] mask, input int ab);
    int nb;
    nb = (lo > hi) ? 8 : int'(hi - lo) * 4 + 12;
    for (int d = 0; d < 2; d++) begin ob[d].done_edge = -1; ob[d].done_cnt = 0; end
    @(negedge clk);
    drive(lo, hi, val, mask, 1'b1, ab == 0);
    @(negedge clk);
    ob[0].busy0 = if1.busy; ob[1].busy0 = if3.busy;
    for (int e = 0; e < nb; e++) begin
      drive(lo, hi, val, mask, 1'b0, ab == e + 1);
      if (if1.done === 1'b1) begin if (ob[0].done_edge < 0) ob[0].done_edge = e; ob[0].done_cnt++; end
      if (if3.done === 1'b1) begin if (ob[1].done_edge < 0) ob[1].done_edge = e; ob[1].done_cnt++; end
      @(negedge clk);
    end
    drive(lo, hi, val, mask, 1'b0, 1'b0);
    snap();
  endtask

  task automatic test_reset();
    #2;
    snap();
    for (int d = 0; d < 2; d++) begin
      tests++; if (ob[d].kout !== 32'h0) begin fails++; $display("FAIL reset key_out lat%0d got %h exp 0", lat_of(d), ob[d].kout); end
      tests++; if (ob[d].busy_end !== 1'b0) begin fails++; $display("FAIL reset busy lat%0d got %b exp 0", lat_of(d), ob[d].busy_end); end
      tests++; if (ob[d].done_now !== 1'b0) begin fails++; $display("FAIL reset done lat%0d got %b exp 0", lat_of(d), ob[d].done_now); end
      tests++; if (ob[d].found !== 1'b0) begin fails++; $display("FAIL reset found lat%0d got %b exp 0", lat_of(d), ob[d].found); end
      tests++; if (ob[d].fkey !== 32'h0) begin fails++; $display("FAIL reset found_key lat%0d got %h exp 0", lat_of(d), ob[d].fkey); end
      tests++; if (ob[d].trials !== 32'h0) begin fails++; $display("FAIL reset trial_count lat%0d got %0d exp 0", lat_of(d), ob[d].trials); end
      tests++; if (ob[d].hits !== 32'h0) begin fails++; $display("FAIL reset hit_count lat%0d got %0d exp 0", lat_of(d), ob[d].hits); end
      ex[d].kout = 32'h0;
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spec_vector();
    int   n_exp, de_exp;
    logic [31:0] k_exp;
    dp_mode = 0;
`ifdef KEY_SWEEP_CONTINUE_EN
    n_exp = 6; de_exp = 12; k_exp = 32'h4C6F7455;
`else
    n_exp = 3; de_exp = 6; k_exp = 32'h4C6F7452;
`endif
    model(3, 32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, -1, ex[1]);
    run_sweep(32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, -1);
    ex[0].kout = k_exp;
    tests++; if (ob[0].done_edge != de_exp || ob[0].done_cnt != 1) begin fails++; $display("FAIL spec done lat1 got edge %0d cnt %0d exp edge %0d cnt 1", ob[0].done_edge, ob[0].done_cnt, de_exp); end
    tests++; if (ob[0].found !== 1'b1 || ob[0].fkey !== 32'h4C6F7452) begin fails++; $display("FAIL spec found lat1 got %b/%h exp 1/4c6f7452", ob[0].found, ob[0].fkey); end
    tests++; if (ob[0].trials !== 32'(n_exp) || ob[0].hits !== 32'h1) begin fails++; $display("FAIL spec counts lat1 got %0d/%0d exp %0d/1", ob[0].trials, ob[0].hits, n_exp); end
    tests++; if (ob[0].busy0 !== 1'b1 || ob[0].busy_end !== 1'b0 || ob[0].kout !== k_exp) begin fails++; $display("FAIL spec busy/key lat1 got %b%b/%h exp 10/%h", ob[0].busy0, ob[0].busy_end, ob[0].kout, k_exp); end
    tests++; if (ob[1].done_edge != ex[1].done_edge || ob[1].done_cnt != 1) begin fails++; $display("FAIL spec done lat3 got edge %0d cnt %0d exp edge %0d cnt 1", ob[1].done_edge, ob[1].done_cnt, ex[1].done_edge); end
    tests++; if (ob[1].fkey !== ex[1].fkey || ob[1].trials !== ex[1].trials || ob[1].hits !== ex[1].hits) begin fails++; $display("FAIL spec result lat3 got %h/%0d/%0d exp %h/%0d/%0d", ob[1].fkey, ob[1].trials, ob[1].hits, ex[1].fkey, ex[1].trials, ex[1].hits); end
  endtask

  task automatic test_empty_range();
    for (int d = 0; d < 2; d++) model(lat_of(d), 32'd10, 32'd5, 32'h0, 32'h0, -1, ex[d]);
    run_sweep(32'd10, 32'd5, 32'h0, 32'h0, -1);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ob[d].done_edge != 1 || ob[d].done_cnt != 1) begin fails++; $display("FAIL empty done lat%0d got edge %0d cnt %0d exp edge 1 cnt 1", lat_of(d), ob[d].done_edge, ob[d].done_cnt); end
      tests++; if (ob[d].found !== 1'b0 || ob[d].trials !== 32'h0 || ob[d].hits !== 32'h0) begin fails++; $display("FAIL empty result lat%0d got %b/%0d/%0d exp 0/0/0", lat_of(d), ob[d].found, ob[d].trials, ob[d].hits); end
      tests++; if (ob[d].kout !== ex[d].kout) begin fails++; $display("FAIL empty key_out lat%0d got %h exp %h", lat_of(d), ob[d].kout, ex[d].kout); end
    end
  endtask

  task automatic test_top_boundary();
    dp_mode = 0;
    model(1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, -1, ex[0]);
    run_sweep(32'hFFFFFFFE, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, -1);
    ex[1].kout = 32'hFFFFFFFF;
    tests++; if (ob[1].trials !== 32'd2 || ob[1].found !== 1'b0) begin fails++; $display("FAIL top result lat3 got %0d/%b exp 2/0", ob[1].trials, ob[1].found); end
    tests++; if (ob[1].kout !== 32'hFFFFFFFF) begin fails++; $display("FAIL top key_out lat3 got %h exp ffffffff", ob[1].kout); end
    tests++; if (ob[1].done_edge != 8 || ob[1].done_cnt != 1) begin fails++; $display("FAIL top done lat3 got edge %0d cnt %0d exp edge 8 cnt 1", ob[1].done_edge, ob[1].done_cnt); end
    tests++; if (ob[0].trials !== ex[0].trials || ob[0].kout !== ex[0].kout || ob[0].done_edge != ex[0].done_edge) begin fails++; $display("FAIL top lat1 got %0d/%h/%0d exp %0d/%h/%0d", ob[0].trials, ob[0].kout, ob[0].done_edge, ex[0].trials, ex[0].kout, ex[0].done_edge); end
  endtask

  task automatic test_single_key();
    logic [31:0] k;
    dp_mode = 1;
    k = $urandom;
    for (int d = 0; d < 2; d++) model(lat_of(d), k, k, ~dp_f(1, k), 32'hFFFFFFFF, -1, ex[d]);
    run_sweep(k, k, ~dp_f(1, k), 32'hFFFFFFFF, -1);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ob[d].trials !== 32'd1 || ob[d].kout !== k) begin fails++; $display("FAIL single lat%0d got %0d/%h exp 1/%h", lat_of(d), ob[d].trials, ob[d].kout, k); end
      tests++; if (ob[d].done_edge != lat_of(d) + 1) begin fails++; $display("FAIL single done lat%0d got %0d exp %0d", lat_of(d), ob[d].done_edge, lat_of(d) + 1); end
    end
  endtask

  task automatic test_abort();
    dp_mode = 0;
    model(3, 32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, 4, ex[1]);
    run_sweep(32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, 4);
    ex[0].kout = 32'h4C6F7452;
    tests++; if (ob[0].done_cnt != 0 || ob[0].found !== 1'b0 || ob[0].busy_end !== 1'b0) begin fails++; $display("FAIL abort lat1 got done %0d found %b busy %b exp 0/0/0", ob[0].done_cnt, ob[0].found, ob[0].busy_end); end
    tests++; if (ob[0].trials !== 32'd2 || ob[0].kout !== 32'h4C6F7452) begin fails++; $display("FAIL abort state lat1 got %0d/%h exp 2/4c6f7452", ob[0].trials, ob[0].kout); end
    tests++; if (ob[1].done_cnt != ex[1].done_cnt || ob[1].trials !== ex[1].trials || ob[1].kout !== ex[1].kout) begin fails++; $display("FAIL abort lat3 got %0d/%0d/%h exp %0d/%0d/%h", ob[1].done_cnt, ob[1].trials, ob[1].kout, ex[1].done_cnt, ex[1].trials, ex[1].kout); end
    for (int d = 0; d < 2; d++) model(lat_of(d), 32'h4C6F7451, 32'h4C6F7453, 32'h12345678, 32'hFFFFFFFF, 0, ex[d]);
    run_sweep(32'h4C6F7451, 32'h4C6F7453, 32'h12345678, 32'hFFFFFFFF, 0);
    for (int d = 0; d < 2; d++) begin
      tests++; if (ob[d].done_edge != ex[d].done_edge || ob[d].fkey !== ex[d].fkey) begin fails++; $display("FAIL start_with_abort lat%0d got %0d/%h exp %0d/%h", lat_of(d), ob[d].done_edge, ob[d].fkey, ex[d].done_edge, ex[d].fkey); end
    end
  endtask

  task automatic test_random();
    logic [31:0] lo, hi, val, mask;
    longint unsigned top;
    int len, ab;
    dp_mode = 1;
    for (int it = 0; it < 30; it++) begin
      lo  = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 12)) : $urandom;
      len = $urandom_range(0, 20);
      top = longint'(lo) + longint'(len);
      hi  = (top > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(top);
      if ($urandom_range(0, 7) == 0 && lo != 0) hi = lo - 32'($urandom_range(1, 3) % (lo + 1));
      val = dp_f(1, lo + 32'($urandom_range(0, len + 4)));
      case ($urandom_range(0, 3))
        0: mask = 32'hFFFFFFFF;
        1: mask = $urandom & $urandom & $urandom;
        2: mask = 32'h0;
        default: mask = 32'h0000FFFF;
      endcase
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
      for (int d = 0; d < 2; d++) model(lat_of(d), lo, hi, val, mask, ab, ex[d]);
      run_sweep(lo, hi, val, mask, ab);
      for (int d = 0; d < 2; d++) begin
        tests++; if (ob[d].done_edge != ex[d].done_edge || ob[d].done_cnt != ex[d].done_cnt) begin fails++; $display("FAIL rnd%0d done lat%0d got %0d/%0d exp %0d/%0d", it, lat_of(d), ob[d].done_edge, ob[d].done_cnt, ex[d].done_edge, ex[d].done_cnt); end
        tests++; if (ob[d].found !== ex[d].found || ob[d].fkey !== ex[d].fkey) begin fails++; $display("FAIL rnd%0d found lat%0d got %b/%h exp %b/%h", it, lat_of(d), ob[d].found, ob[d].fkey, ex[d].found, ex[d].fkey); end
        tests++; if (ob[d].trials !== ex[d].trials || ob[d].hits !== ex[d].hits) begin fails++; $display("FAIL rnd%0d counts lat%0d got %0d/%0d exp %0d/%0d", it, lat_of(d), ob[d].trials, ob[d].hits, ex[d].trials, ex[d].hits); end
        tests++; if (ob[d].kout !== ex[d].kout || ob[d].busy0 !== 1'b1 || ob[d].busy_end !== 1'b0) begin fails++; $display("FAIL rnd%0d key/busy lat%0d got %h/%b%b exp %h/10", it, lat_of(d), ob[d].kout, ob[d].busy0, ob[d].busy_end, ex[d].kout); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int dn1, dn3;
    dp_mode = 0;
    @(negedge clk);
    drive(32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    drive(32'h4C6F7450, 32'h4C6F7455, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1 snap();
    for (int d = 0; d < 2; d++) begin
      tests++; if (ob[d].kout !== 32'h0 || ob[d].busy_end !== 1'b0 || ob[d].done_now !== 1'b0) begin fails++; $display("FAIL midrst ctl lat%0d got %h/%b/%b exp 0/0/0", lat_of(d), ob[d].kout, ob[d].busy_end, ob[d].done_now); end
      tests++; if (ob[d].found !== 1'b0 || ob[d].fkey !== 32'h0 || ob[d].trials !== 32'h0 || ob[d].hits !== 32'h0) begin fails++; $display("FAIL midrst result lat%0d got %b/%h/%0d/%0d exp 0/0/0/0", lat_of(d), ob[d].found, ob[d].fkey, ob[d].trials, ob[d].hits); end
      ex[d].kout = 32'h0;
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dn1 = 0; dn3 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if1.done !== 1'b0) dn1++;
      if (if3.done !== 1'b0) dn3++;
    end
    tests++; if (dn1 != 0 || dn3 != 0 || if1.busy !== 1'b0 || if3.busy !== 1'b0) begin fails++; $display("FAIL midrst idle got done %0d/%0d busy %b/%b exp 0/0 0/0", dn1, dn3, if1.busy, if3.busy); end
  endtask

  initial begin
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_spec_vector();
    test_empty_range();
    test_top_boundary();
    test_single_key();
    test_abort();
    test_random();
    test_reset_mid_sweep();
    test_spec_vector();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
